// File: rtl/dual_input_debouncer.sv
// Two-channel synchronise-and-debounce front end for the two-input gate blocks.
// Each raw level passes a two-flop synchroniser, then must hold its new value
// for DEBOUNCE_CYCLES consecutive clocks before the stable output follows.
// Registered one-cycle rise/fall pulses accompany every change of the output.

module dual_input_debouncer_channel #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Terminal count: the flip happens on the cycle that would otherwise
  // advance the counter past this value, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only s2 is allowed to feed the debounce logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_raw;
      s2 <= s1;
    end
  end

  // Count consecutive disagreement between s2 and the output; any agreement
  // restarts the count, so short glitches never accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (s2 == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt     <= '0;
        o_level <= s2;
        o_rise  <= s2;
        o_fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw_a,
  input  logic i_raw_b,
  output logic o_a,
  output logic o_b,
  output logic o_a_rise,
  output logic o_a_fall,
  output logic o_b_rise,
  output logic o_b_fall
);

  // Channels share nothing but clock and reset.
  dual_input_debouncer_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_raw_a),
    .o_level(o_a),
    .o_rise (o_a_rise),
    .o_fall (o_a_fall)
  );

  dual_input_debouncer_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_raw_b),
    .o_level(o_b),
    .o_rise (o_b_rise),
    .o_fall (o_b_fall)
  );

endmodule
